// File: rtl/riscv_dmem_arbiter.sv
// Two-port arbiter in front of the single word-addressed data-memory port.
// Port 0 is the processor data path and port 1 is the debug/loader engine.
// It grants at most one requester per cycle, either round-robin or with port 0
// always winning. It tracks which port owns the in-flight read, steers read data
// back to that owner, and flags accesses that fall outside data space.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   m{0,1}_req/we/addr/wdata        requester inputs
//   m{0,1}_gnt                      combinational grant, same cycle as req
//   m{0,1}_rvalid/rdata/err         response, one cycle after the grant
//   mem_addr/we/wdata, mem_rdata    memory port (synchronous 1-cycle read)
module riscv_dmem_arbiter #(
   parameter logic [31:0] DATA_START_ADDRESS = 32'h0080_0000,
   parameter int unsigned DATA_BRAMS         = 2,
   parameter bit          FIXED_PRIORITY     = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned ABITS = 11 + DATA_BRAMS;

   typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;

   owner_t rd_owner, rd_owner_n;
   logic   err_pend, err_pend_n;
   logic   werr0, werr0_n, werr1, werr1_n;
   logic   last_gnt, last_gnt_n;

   logic        g0, g1, any_gnt, sel_we, in_range;
   logic [31:0] sel_addr;

   // Grant: a lone requester wins; on contention, fixed or alternating winner
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (rst) begin
         if (m0_req && m1_req) begin
            if (FIXED_PRIORITY || last_gnt) g0 = 1'b1;
            else                            g1 = 1'b1;
         end else begin
            g0 = m0_req;
            g1 = m1_req;
         end
      end
   end

   // Memory drive follows the granted port; port 0 values when idle
   assign any_gnt   = g0 | g1;
   assign sel_addr  = g1 ? m1_addr : m0_addr;
   assign sel_we    = g1 ? m1_we : m0_we;
   assign in_range  = (sel_addr[31:ABITS] == DATA_START_ADDRESS[31:ABITS]);
   assign mem_addr  = sel_addr;
   assign mem_wdata = g1 ? m1_wdata : m0_wdata;
   assign mem_we    = any_gnt & sel_we & in_range;
   assign m0_gnt    = g0;
   assign m1_gnt    = g1;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_owner <= OWN_NONE;
         err_pend <= 1'b0;
         werr0    <= 1'b0;
         werr1    <= 1'b0;
         last_gnt <= 1'b1;
      end else begin
         rd_owner <= rd_owner_n;
         err_pend <= err_pend_n;
         werr0    <= werr0_n;
         werr1    <= werr1_n;
         last_gnt <= last_gnt_n;
      end
   end

   // Next state: each grant schedules exactly one response slot next cycle
   always_comb begin
      rd_owner_n = OWN_NONE;
      err_pend_n = 1'b0;
      werr0_n    = 1'b0;
      werr1_n    = 1'b0;
      last_gnt_n = last_gnt;
      if (any_gnt) begin
         last_gnt_n = g1;
         if (sel_we) begin
            werr0_n = g0 & ~in_range;
            werr1_n = g1 & ~in_range;
         end else begin
            rd_owner_n = g1 ? OWN_P1 : OWN_P0;
            err_pend_n = ~in_range;
         end
      end
   end

   // Response routing; an out-of-range read returns zero data with err
   always_comb begin
      m0_rvalid = (rd_owner == OWN_P0);
      m1_rvalid = (rd_owner == OWN_P1);
      m0_rdata  = (m0_rvalid && !err_pend) ? mem_rdata : 32'h0;
      m1_rdata  = (m1_rvalid && !err_pend) ? mem_rdata : 32'h0;
      m0_err    = (m0_rvalid && err_pend) || werr0;
      m1_err    = (m1_rvalid && err_pend) || werr1;
   end

endmodule

// File: doc/riscv_dmem_arbiter.md
Name: riscv_dmem_arbiter

Overview:
- Shares the single data-memory port of the RISC-V memory block between two requesters:
  - port 0: processor data path.
  - port 1: debug/loader engine, e.g. a UART program loader.
- The memory port is word-addressed and has a synchronous read with 1-cycle latency. Writes go through only when the address is in data space.
- This block arbitrates per cycle, tracks the owner of each in-flight read, routes read data back to that owner, and flags out-of-range accesses.

Parameters:
- DATA_START_ADDRESS, 32'h00800000, base of data space.
- DATA_BRAMS, 2, data memory size; address bits = 11 + DATA_BRAMS.
- FIXED_PRIORITY, 0, 0 = round-robin, 1 = port 0 always wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  32  port 0 byte address.
- m0_wdata  in  32  port 0 write data.
- m0_gnt  out  1  port 0 access accepted this cycle.
- m0_rvalid  out  1  port 0 read data valid.
- m0_rdata  out  32  port 0 read data.
- m0_err  out  1  port 0 out-of-range access; pulses with the response.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: identical to port 0, for port 1.
- mem_addr  out  32  to memory dAddress.
- mem_we  out  1  to memory MemWrite.
- mem_wdata  out  32  to memory dWriteData.
- mem_rdata  in  32  from memory dReadData.

Behaviour:
- Reset (rst=0, asynchronous): all state cleared immediately.
  - rd_owner = NONE, err_pend = 0, last_gnt = 1, so port 0 wins the first contention.
  - m*_rvalid = 0, m*_err = 0, m*_rdata = 0.
  - Combinational outputs m*_gnt and mem_we are forced 0 while rst=0.
- Grant (combinational, same cycle as req):
  - Only one requester: it is granted.
  - Both requesting, FIXED_PRIORITY=1: port 0 wins.
  - Both requesting, FIXED_PRIORITY=0: the port not equal to last_gnt wins.
  - The losing port's req must stay asserted with stable inputs until granted.
  - Exactly one gnt is high per cycle, at most.
- last_gnt: updated on the clock edge to the index of the granted port. Unchanged in a cycle with no grant.
- Memory drive:
  - mem_addr/mem_wdata = the granted port's addr/wdata.
  - With no grant, they take port 0's values; mem_we = 0.
  - mem_we = granted port's we AND in_range.
  - in_range = (addr[31:11+DATA_BRAMS] == DATA_START_ADDRESS[31:11+DATA_BRAMS]).
  - Address bits [1:0] are ignored (word access only).
- Writes: gnt marks completion. No rvalid is produced.
  - An out-of-range write is granted but suppressed (mem_we=0).
  - The next cycle, that port's err = 1 for exactly 1 cycle.
- Reads:
  - On a granted read, rd_owner <= granted port and err_pend <= !in_range.
  - Next cycle, the owner's rvalid = 1 and its rdata = mem_rdata, or 0 when err_pend is set.
  - err = err_pend in that same cycle.
  - Non-owner rdata = 0 and rvalid = 0.
- Back-to-back: a new grant is allowed every cycle, including while a previous read response is being delivered. Full throughput is 1 access/cycle.
- rd_owner returns to NONE on the edge after a response if there is no new read grant.
- Reset mid-read: the pending response is discarded and no rvalid is ever produced for it.
- Simultaneous events:
  - A write to address A in cycle N, then a read of A in cycle N+1, returns the new data.
  - A read and write of the same address in the same cycle is impossible (single grant).

Test Plan:
- Reset released, m0 read 0x00800004 while memory word 1 = 0xDEADBEEF:
  - m0_gnt=1 in the same cycle.
  - Next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m0_err=0.
  - m1 outputs all 0.
- m0 and m1 both request every cycle for 6 cycles, FIXED_PRIORITY=0:
  - Grants alternate 0,1,0,1,0,1.
  - With FIXED_PRIORITY=1, all 6 grants go to m0.
- m1 writes 0x12345678 to 0x00800010, then m0 reads 0x00800010 the next cycle:
  - mem_we=1 in the first cycle only.
  - m0_rdata=0x12345678 one cycle after its grant.
- m1 writes 0x00400000 (out of range):
  - mem_we=0 and m1_gnt=1.
  - Next cycle m1_err=1 for 1 cycle, m1_rvalid=0.
  - An out-of-range read returns rvalid=1, rdata=0, err=1.
- m0 read granted, rst pulled low mid-cycle before the response edge:
  - All outputs go to 0 immediately.
  - After release, no stray rvalid appears.
  - The first contended grant goes to m0.
- Reads interleaved every cycle: m0 at 0x00800000, m1 at 0x00800004, memory words 0xA and 0xB:
  - Each response appears only on its owner's port.
  - m0_rdata=0xA and m1_rdata=0xB, on alternating cycles with no gaps.
